// File: rtl/inst_fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | inst_fetch_queue: {inst, pc} buffer between instruction memory and ID,   |
// | with immediate-type pre-decode at push time and a one-cycle flush.       |
// | Optional: IFQ_BYPASS_EN passes the input straight to the output when     |
// | the queue is empty.                                                      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

`ifndef ITYPE
`define ITYPE 3'd0
`endif
`ifndef STYPE
`define STYPE 3'd1
`endif
`ifndef BTYPE
`define BTYPE 3'd2
`endif
`ifndef UTYPE
`define UTYPE 3'd3
`endif
`ifndef JTYPE
`define JTYPE 3'd4
`endif
`ifndef RTYPE
`define RTYPE 3'd5
`endif

module inst_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_inst,
  input  logic [31:0]   in_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_inst,
  output logic [31:0]   out_pc,
  output logic [2:0]    out_imm_type,
  output logic          out_illegal,
  output logic [AW:0]   count
);

  localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);
  localparam logic [31:0] c_nop   = 32'h0000_0013;

  logic [31:0]   inst_mem_q [DEPTH];
  logic [31:0]   pc_mem_q   [DEPTH];
  logic [2:0]    imm_mem_q  [DEPTH];
  logic          ill_mem_q  [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;

  logic [2:0]    w_dec_imm_type;
  logic          w_dec_illegal;
  logic          w_empty;
  logic          w_bypass;
  logic          w_bypass_take;
  logic          w_push;
  logic          w_pop;

  // Pre-decode of the incoming opcode; stored with the entry so ID sees it registered.
  always_comb begin
    w_dec_imm_type = `RTYPE;
    w_dec_illegal  = 1'b0;
    case (in_inst[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: w_dec_imm_type = `ITYPE;
      7'b0100011:                         w_dec_imm_type = `STYPE;
      7'b1100011:                         w_dec_imm_type = `BTYPE;
      7'b0110111, 7'b0010111:             w_dec_imm_type = `UTYPE;
      7'b1101111:                         w_dec_imm_type = `JTYPE;
      7'b0110011:                         w_dec_imm_type = `RTYPE;
      default:                            w_dec_illegal  = 1'b1;
    endcase
  end

  always_comb begin
    w_empty  = (count_q == '0);
    in_ready = (count_q != c_depth);
    count    = count_q;
    w_bypass = 1'b0;
`ifdef IFQ_BYPASS_EN
    w_bypass = w_empty && rst_n && !flush;
`endif

    if (w_bypass) begin
      out_valid    = in_valid;
      out_inst     = in_inst;
      out_pc       = in_pc;
      out_imm_type = w_dec_imm_type;
      out_illegal  = w_dec_illegal;
    end else if (w_empty) begin
      out_valid    = 1'b0;
      out_inst     = c_nop;
      out_pc       = 32'h0;
      out_imm_type = `ITYPE;
      out_illegal  = 1'b0;
    end else begin
      out_valid    = 1'b1;
      out_inst     = inst_mem_q[rd_ptr_q];
      out_pc       = pc_mem_q[rd_ptr_q];
      out_imm_type = imm_mem_q[rd_ptr_q];
      out_illegal  = ill_mem_q[rd_ptr_q];
    end

    // A bypassed word that is consumed on the spot never enters storage.
    w_bypass_take = w_bypass && in_valid && out_ready;
    w_push        = rst_n && !flush && in_valid && in_ready && !w_bypass_take;
    w_pop         = rst_n && !flush && !w_empty && out_ready;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      inst_mem_q[wr_ptr_q] <= in_inst;
      pc_mem_q[wr_ptr_q]   <= in_pc;
      imm_mem_q[wr_ptr_q]  <= w_dec_imm_type;
      ill_mem_q[wr_ptr_q]  <= w_dec_illegal;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_inst_fetch_queue: scoreboard bench for inst_fetch_queue.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

`ifndef ITYPE
`define ITYPE 3'd0
`endif
`ifndef STYPE
`define STYPE 3'd1
`endif
`ifndef BTYPE
`define BTYPE 3'd2
`endif
`ifndef UTYPE
`define UTYPE 3'd3
`endif
`ifndef JTYPE
`define JTYPE 3'd4
`endif
`ifndef RTYPE
`define RTYPE 3'd5
`endif

module tb_inst_fetch_queue;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [2:0]  imm;
    logic        ill;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [2:0]  out_imm_type;
  logic        out_illegal;
  logic [2:0]  count;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic rand_en = 1'b0;

  inst_fetch_queue #(.DEPTH(4), .AW(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_inst      (in_inst),
    .in_pc        (in_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_inst     (out_inst),
    .out_pc       (out_pc),
    .out_imm_type (out_imm_type),
    .out_illegal  (out_illegal),
    .count        (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every handshake on the output side is checked against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && flush === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pop: got pc %h, expected no output", out_pc);
      end else begin
        e = exp_q.pop_front();
        chk("out_inst", out_inst, e.inst);
        chk("out_pc", out_pc, e.pc);
        chk("out_imm_type", {29'd0, out_imm_type}, {29'd0, e.imm});
        chk("out_illegal", {31'd0, out_illegal}, {31'd0, e.ill});
      end
    end
    if (rst_n === 1'b1 && count > 3'd4) begin
      chk("count_max", {29'd0, count}, 32'd4);
    end
  end

  always @(posedge clk) begin
    if (rand_en) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Hold in_valid until the word is taken, then drop it just after the accepting edge.
  task automatic wait_accept();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] inst, input logic [31:0] pc,
                      input logic [2:0] imm, input logic ill);
    exp_t e;
    e.inst = inst;
    e.pc   = pc;
    e.imm  = imm;
    e.ill  = ill;
    exp_q.push_back(e);
    in_inst  = inst;
    in_pc    = pc;
    in_valid = 1'b1;
    wait_accept();
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("drain_left", exp_q.size(), 32'd0);
    #1;
  endtask

  // addi x1, x0, pc[11:0] -- an I-type word tagged with its pc
  function automatic logic [31:0] addi_w(input logic [31:0] pc);
    return {pc[11:0], 20'h00093};
  endfunction

  logic [31:0] dec_inst [7];
  logic [2:0]  dec_imm  [7];
  logic        dec_ill  [7];

  initial begin
    dec_inst[0] = 32'h00500093; dec_imm[0] = `ITYPE; dec_ill[0] = 1'b0;
    dec_inst[1] = 32'h00112623; dec_imm[1] = `STYPE; dec_ill[1] = 1'b0;
    dec_inst[2] = 32'hFE000EE3; dec_imm[2] = `BTYPE; dec_ill[2] = 1'b0;
    dec_inst[3] = 32'h000012B7; dec_imm[3] = `UTYPE; dec_ill[3] = 1'b0;
    dec_inst[4] = 32'h0080006F; dec_imm[4] = `JTYPE; dec_ill[4] = 1'b0;
    dec_inst[5] = 32'h00B50533; dec_imm[5] = `RTYPE; dec_ill[5] = 1'b0;
    dec_inst[6] = 32'hFFFFFFFF; dec_imm[6] = `RTYPE; dec_ill[6] = 1'b1;

    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_inst   = 32'hDEADBEEF;
    in_pc     = 32'h00000080;
    out_ready = 1'b0;

    // Reset with in_valid held high
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_out_inst", out_inst, 32'h00000013);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_imm_type", {29'd0, out_imm_type}, {29'd0, `ITYPE});
    chk("rst_illegal", {31'd0, out_illegal}, 32'd0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;

    // Fill to full, hold a fifth word, then drain in order
    for (int k = 0; k < 4; k++) begin
      send(addi_w(32'(4 * k)), 32'(4 * k), `ITYPE, 1'b0);
    end
    @(negedge clk);
    chk("full_count", {29'd0, count}, 32'd4);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("full_out_pc", out_pc, 32'h0);
    @(posedge clk);
    #1;
    begin
      exp_t e;
      e.inst = addi_w(32'h10);
      e.pc   = 32'h10;
      e.imm  = `ITYPE;
      e.ill  = 1'b0;
      exp_q.push_back(e);
    end
    in_inst  = addi_w(32'h10);
    in_pc    = 32'h10;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("hold_count", {29'd0, count}, 32'd4);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_accept();
    drain();
    @(negedge clk);
    chk("drained_count", {29'd0, count}, 32'd0);
    chk("drained_out_inst", out_inst, 32'h00000013);
    @(posedge clk);
    #1;

    // Pre-decode of each opcode class
    for (int k = 0; k < 7; k++) begin
      send(dec_inst[k], 32'h40 + 32'(4 * k), dec_imm[k], dec_ill[k]);
    end
    drain();

    // Simultaneous push and pop at count=2
    out_ready = 1'b0;
    send(addi_w(32'h100), 32'h100, `ITYPE, 1'b0);
    send(addi_w(32'h104), 32'h104, `ITYPE, 1'b0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      e.inst = addi_w(32'h108 + 32'(4 * k));
      e.pc   = 32'h108 + 32'(4 * k);
      e.imm  = `ITYPE;
      e.ill  = 1'b0;
      exp_q.push_back(e);
      in_inst = e.inst;
      in_pc   = e.pc;
      @(negedge clk);
      chk("pushpop_count", {29'd0, count}, 32'd2);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain();

    // Flush at count=3 while a word is offered
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      send(addi_w(32'h20 + 32'(4 * k)), 32'h20 + 32'(4 * k), `ITYPE, 1'b0);
    end
    flush    = 1'b1;
    in_inst  = addi_w(32'h40);
    in_pc    = 32'h40;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("flush_count", {29'd0, count}, 32'd0);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Reset mid-stream drops entries
    out_ready = 1'b0;
    send(addi_w(32'h60), 32'h60, `ITYPE, 1'b0);
    send(addi_w(32'h64), 32'h64, `ITYPE, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_count", {29'd0, count}, 32'd0);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

`ifdef IFQ_BYPASS_EN
    // Empty queue, consumer ready: the input appears at the output in the same cycle
    begin
      exp_t e;
      e.inst = 32'h00112623;
      e.pc   = 32'h300;
      e.imm  = `STYPE;
      e.ill  = 1'b0;
      exp_q.push_back(e);
      in_inst  = e.inst;
      in_pc    = e.pc;
      in_valid = 1'b1;
      @(negedge clk);
      chk("bypass_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bypass_count", {29'd0, count}, 32'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("bypass_count_after", {29'd0, count}, 32'd0);
      @(posedge clk);
      #1;
    end
`endif

    // Wrap-around stream with a randomly stalling consumer
    rand_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      send(addi_w(32'h200 + 32'(4 * k)), 32'h200 + 32'(4 * k), `ITYPE, 1'b0);
    end
    rand_en = 1'b0;
    @(posedge clk);
    #2;
    drain();
    chk("wrap_all_delivered", exp_q.size(), 32'd0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Instruction buffer between instruction-memory read data and the ID stage.
- Queues {inst, pc} pairs with a valid/ready handshake on each side.
- Pre-decodes the opcode into an immediate type at push time, so decode gets `inst[31:7]` and a ready `imm_type` for the immediate-extend unit without a decode path in front of it.
- Supports a one-cycle flush for branch and jump redirects.

Parameters:
- DEPTH, 4: number of entries; power of two, at least 2.
- AW, 2: pointer width, equal to log2(DEPTH).

Ports:
- clk  input  1  core clock; rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- flush  input  1  discard all entries (redirect from EX).
- in_valid  input  1  in_inst and in_pc are valid.
- in_ready  output  1  the queue can accept a word.
- in_inst  input  32  fetched instruction.
- in_pc  input  32  PC of in_inst.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  ID consumes the head entry.
- out_inst  output  32  head instruction.
- out_pc  output  32  head PC.
- out_imm_type  output  3  immediate type of the head entry, encoded with the shared Parameters.v codes (`ITYPE`, `STYPE`, ...).
- out_illegal  output  1  head opcode is not RV32I.
- count  output  AW+1  current occupancy.

Behaviour:
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready = (count != DEPTH). It is derived from registered count only. There is no push-while-full-with-pop bypass.
- out_valid = (count != 0). The head is first-word-fall-through from storage.
- Latency is one cycle: a word pushed at edge N is visible at the outputs after edge N.
- Each entry stores {inst, pc, imm_type, illegal}.
- imm_type and illegal are decoded from in_inst[6:0] at push time:
  - 0010011, 0000011, 1100111 → `ITYPE`
  - 0100011 → `STYPE`
  - 1100011 → `BTYPE`
  - 0110111, 0010111 → `UTYPE`
  - 1101111 → `JTYPE`
  - 0110011 → `RTYPE`
  - anything else → `RTYPE` with illegal=1
- Simultaneous push and pop: count unchanged, both pointers advance, order preserved. Push and pop cannot both occur when full.
- Pointers are AW bits and wrap modulo DEPTH. count is AW+1 bits, range 0..DEPTH.
- When empty, outputs are forced: out_inst = 32'h00000013 (NOP), out_pc = 0, out_imm_type = `ITYPE`, out_illegal = 0.
- Flush at edge N:
  - Pointers and count reset to 0.
  - Any push or pop in that cycle is ignored.
  - out_valid = 0 and in_ready = 1 after edge N.
- Reset with rst_n low at an edge:
  - Same effect as flush, and takes priority over flush.
  - Storage contents are not reset.
  - Outputs take their empty values after the edge.
  - Reset mid-stream drops all entries.
- in_inst and in_pc are ignored when in_valid is low.
- Outputs are stable while out_valid && !out_ready, except on flush or reset.

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- Defined:
  - When count == 0 and no flush, the input is passed combinationally to the outputs: out_valid = in_valid, with out_inst, out_pc and the decoded imm_type/illegal taken from the input.
  - If out_ready is also high, the word is consumed without being written and count stays 0 (zero latency).
  - If out_ready is low, the word is pushed normally.
- Undefined:
  - Fixed one-cycle latency. No combinational path from in_* to out_*.

Test Plan:
- Reset: rst_n low for 2 cycles with in_valid=1 → out_valid=0, in_ready=1, count=0, out_inst=32'h00000013, out_pc=0.
- Fill and drain (DEPTH=4):
  - Push pc 0x0/0x4/0x8/0xC with out_ready=0 → count=4, in_ready=0.
  - A fifth word held on the input is not accepted.
  - Set out_ready=1 → words exit in pc order 0x0, 0x4, 0x8, 0xC, then the fifth.
- Decode: push each word below, then pop → out_imm_type and out_illegal as listed.
  - 0x00500093 → `ITYPE`
  - 0x00112623 → `STYPE`
  - 0xFE000EE3 → `BTYPE`
  - 0x000012B7 → `UTYPE`
  - 0x0080006F → `JTYPE`
  - 0x00B50533 → `RTYPE`
  - 0xFFFFFFFF → `RTYPE`, illegal=1
- Simultaneous push and pop: at count=2, in_valid=out_ready=1 for 3 cycles → count stays 2 and the output pc sequence is strictly increasing.
- Flush: at count=3, flush=1 with in_valid=1 (pc 0x40) → next cycle count=0, out_valid=0; pc 0x40 never appears at the output.
- Wrap-around: stream 10 words with randomized out_ready → all 10 are delivered in order with no loss or duplication, count never exceeds 4, and (IFQ_BYPASS_EN only) with out_ready=1 and an empty queue, out_valid follows in_valid in the same cycle.
